// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encoding
// and the default load base address.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_ERROR   = 3'd4
    } state_e;

    localparam int DEF_BASE_ADDR = 0;

endpackage

// File: rtl/program_loader_if.sv
// Word-stream valid/ready handshake feeding the program loader.
// master = stream source, slave = loader.
interface program_loader_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  in_ready;

    modport master (output in_valid, in_data, in_last, input in_ready);
    modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/program_loader_checksum.sv
// Running-sum accumulator used to validate the trailing checksum word.
// Only built when PROGRAM_LOADER_CHECKSUM_EN is defined.
`ifdef PROGRAM_LOADER_CHECKSUM_EN
module program_loader_checksum #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  add,
    input  logic [DATA_WIDTH-1:0] add_data,
    input  logic [DATA_WIDTH-1:0] cmp_data,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  match
);
    logic [DATA_WIDTH-1:0] sum_q, sum_d;

    // Next sum: clear wins over add; wraps modulo 2**DATA_WIDTH.
    always_comb begin
        sum_d = sum_q;
        if (clr)      sum_d = '0;
        else if (add) sum_d = sum_q + add_data;
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end

    assign sum   = sum_q;
    assign match = (sum_q == cmp_data);
endmodule
`endif

// File: rtl/program_loader.sv
// Boot-time program loader: writes a valid/ready word stream into
// instruction memory from BASE_ADDR upward, holding the CPU in reset until
// the final word is committed. Optional feature macro:
// PROGRAM_LOADER_CHECKSUM_EN (last word is a checksum, not program data).
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int BASE_ADDR  = DEF_BASE_ADDR
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    program_loader_if.slave       s_if,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_reset_n,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);
    localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]   wc_q, wc_d;
    logic                  we_q, we_d;
    logic                  ready_q, cpu_rst_n_q, done_q, error_q;
    logic                  accept, do_write;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic csum_clr, csum_add, csum_match;

    program_loader_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_csum (
        .clk      (clk),
        .rst_n    (reset_n),
        .clr      (csum_clr),
        .add      (csum_add),
        .add_data (s_if.in_data),
        .cmp_data (s_if.in_data),
        .sum      (checksum),
        .match    (csum_match)
    );
`endif

    // Next-state/write decode; start overrides everything, including a
    // simultaneous handshake (that word is dropped).
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        wc_d     = wc_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        do_write = 1'b0;
        accept   = (state_q == ST_LOAD) && ready_q && s_if.in_valid;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_clr = start;
        csum_add = 1'b0;
`endif
        if (start) begin
            state_d = ST_LOAD;
            ptr_d   = BASE;
            wc_d    = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        if (s_if.in_last) begin
                            state_d = csum_match ? ST_RELEASE : ST_ERROR;
                        end else begin
                            do_write = 1'b1;
                            csum_add = 1'b1;
                            if (ptr_q == PTR_MAX) state_d = ST_ERROR;
                        end
`else
                        do_write = 1'b1;
                        if (s_if.in_last)          state_d = ST_RELEASE;
                        else if (ptr_q == PTR_MAX) state_d = ST_ERROR;
`endif
                    end
                end
                ST_RELEASE: state_d = ST_RUN;
                default: ;
            endcase
        end
        // Pointer saturates at the top so memory never wraps onto BASE_ADDR.
        if (do_write) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = s_if.in_data;
            wc_d    = wc_q + (ADDR_WIDTH+1)'(1);
            if (ptr_q != PTR_MAX) ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
    end

    // State, counters and registered outputs (decoded from next state).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= BASE;
            wc_q        <= '0;
            we_q        <= 1'b0;
            addr_q      <= BASE;
            wdata_q     <= '0;
            ready_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wc_q        <= wc_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= (state_d == ST_LOAD);
            cpu_rst_n_q <= (state_d == ST_RUN);
            done_q      <= (state_d == ST_RUN);
            error_q     <= (state_d == ST_ERROR);
        end
    end

    assign s_if.in_ready = ready_q;
    assign imem_we       = we_q;
    assign imem_addr     = addr_q;
    assign imem_wdata    = wdata_q;
    assign cpu_reset_n   = cpu_rst_n_q;
    assign done          = done_q;
    assign error         = error_q;
    assign word_count    = wc_q;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader (ADDR_WIDTH=2): a vector table for the main load
// flow, hand sequences for restart/overflow/exact-fit/async reset, and a
// write scoreboard checking every imem write. Works with or without
// PROGRAM_LOADER_CHECKSUM_EN.
module tb_program_loader;
    typedef struct packed { logic [1:0] a; logic [31:0] d; } wr_t;
    typedef struct {
        logic st, v; logic [31:0] d; logic l, acc;
        logic rdy, cpu, dn, er; logic [2:0] wc;
    } vec_t;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam int LASTW = 0;
`else
    localparam int LASTW = 1;
`endif

    logic        clk, reset_n, start;
    logic        imem_we, cpu_reset_n, done, error;
    logic [1:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [2:0]  word_count;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int   n_chk = 0, n_fail = 0;
    wr_t  sb[$];
    wr_t  mon_e;
    logic [1:0] exp_ptr = 2'd0;
    vec_t tbl[6];

    program_loader_if #(.DATA_WIDTH(32)) s_if ();

    program_loader #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .BASE_ADDR(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .s_if(s_if),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset_n(cpu_reset_n), .done(done), .error(error),
        .word_count(word_count)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic rdy, input logic cpu,
                          input logic dn, input logic er, input logic [2:0] wc);
        chk({tag, ".in_ready"},    64'(s_if.in_ready), 64'(rdy));
        chk({tag, ".cpu_reset_n"}, 64'(cpu_reset_n),   64'(cpu));
        chk({tag, ".done"},        64'(done),          64'(dn));
        chk({tag, ".error"},       64'(error),         64'(er));
        chk({tag, ".word_count"},  64'(word_count),    64'(wc));
    endtask

    function automatic vec_t mk(input logic st, v, input logic [31:0] d, input logic l, acc,
                                input logic rdy, cpu, dn, er, input logic [2:0] wc);
        mk = '{st:st, v:v, d:d, l:l, acc:acc, rdy:rdy, cpu:cpu, dn:dn, er:er, wc:wc};
    endfunction

    task automatic push(input logic [31:0] d);
        sb.push_back('{a:exp_ptr, d:d});
        exp_ptr = exp_ptr + 2'd1;
    endtask

    // One clock of stimulus; acc says the loader is expected to be ready.
    task automatic cyc(input logic st, input logic v, input logic [31:0] d,
                       input logic l, input logic acc);
        start = st; s_if.in_valid = v; s_if.in_data = d; s_if.in_last = l;
        if (st) exp_ptr = 2'd0;
        else if (acc && v) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (!l) push(d);
`else
            push(d);
`endif
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; s_if.in_valid = 1'b0; s_if.in_last = 1'b0;
    endtask

    // Scoreboard: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (reset_n && imem_we) begin
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_write: addr=%0d data=0x%h, no write expected",
                         imem_addr, imem_wdata);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", 64'(imem_addr), 64'(mon_e.a));
                chk("wr_data", 64'(imem_wdata), 64'(mon_e.d));
            end
        end
    end

    initial begin
        reset_n = 1'b0; start = 1'b0;
        s_if.in_valid = 1'b0; s_if.in_data = '0; s_if.in_last = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        tbl[0] = mk(1, 0, 32'h0, 0, 0,  1, 0, 0, 0, 3'd0);
        tbl[1] = mk(0, 1, 32'd1, 0, 1,  1, 0, 0, 0, 3'd1);
        tbl[2] = mk(0, 1, 32'd2, 0, 1,  1, 0, 0, 0, 3'd2);
        tbl[3] = mk(0, 1, 32'd3, 0, 1,  1, 0, 0, 0, 3'd3);
        tbl[4] = mk(0, 1, 32'd6, 1, 1,  0, 0, 0, 0, 3'd3);
        tbl[5] = mk(0, 0, 32'h0, 0, 0,  0, 1, 1, 0, 3'd3);
`else
        tbl[0] = mk(1, 0, 32'h0,        0, 0,  1, 0, 0, 0, 3'd0);
        tbl[1] = mk(0, 1, 32'h20080005, 0, 1,  1, 0, 0, 0, 3'd1);
        tbl[2] = mk(0, 1, 32'h20090003, 0, 1,  1, 0, 0, 0, 3'd2);
        tbl[3] = mk(0, 1, 32'h01095020, 1, 1,  0, 0, 0, 0, 3'd3);
        tbl[4] = mk(0, 0, 32'h0,        0, 0,  0, 1, 1, 0, 3'd3);
        tbl[5] = mk(0, 1, 32'hDEADBEEF, 1, 0,  0, 1, 1, 0, 3'd3);
`endif
        repeat (2) @(negedge clk);
        chk_st("reset", 0, 0, 0, 0, 3'd0);
        chk("reset.imem_we",    64'(imem_we),    64'(0));
        chk("reset.imem_addr",  64'(imem_addr),  64'(0));
        chk("reset.imem_wdata", 64'(imem_wdata), 64'(0));
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_st("idle", 0, 0, 0, 0, 3'd0);
        end

        // Main load flow from the vector table.
        for (int i = 0; i < 6; i++) begin
            cyc(tbl[i].st, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].acc);
            chk_st($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].cpu, tbl[i].dn, tbl[i].er, tbl[i].wc);
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        chk("vec.checksum", 64'(checksum), 64'(6));
`endif

        // Restart from RUN, start mid-load, start colliding with a handshake.
        cyc(1, 0, 32'h0, 0, 0);      chk_st("restart", 1, 0, 0, 0, 3'd0);
        cyc(0, 1, 32'hA1, 0, 1);
        cyc(0, 1, 32'hA2, 0, 1);     chk_st("mid2", 1, 0, 0, 0, 3'd2);
        cyc(1, 1, 32'hBAD, 0, 1);    chk_st("start_wins", 1, 0, 0, 0, 3'd0);
        // Gappy valid: only handshaked words land, contiguously from 0.
        cyc(0, 1, 32'h111, 0, 1);
        cyc(0, 0, 32'h0, 0, 0);
        cyc(0, 1, 32'h222, 0, 1);
        cyc(0, 0, 32'h0, 0, 0);
        cyc(0, 0, 32'h0, 0, 0);
        cyc(0, 1, 32'h333, 1, 1);    chk_st("gap_last", 0, 0, 0, 0, 3'(2 + LASTW));
        cyc(0, 0, 32'h0, 0, 0);      chk_st("gap_run", 0, 1, 1, 0, 3'(2 + LASTW));

        // Overflow: four words fill memory, the fifth is refused.
        cyc(1, 0, 32'h0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'h40 + 32'(i), 0, 1);
        chk_st("ovf", 0, 0, 0, 1, 3'd4);
        cyc(0, 1, 32'h99, 0, 0);     chk_st("ovf_hold", 0, 0, 0, 1, 3'd4);
        cyc(0, 1, 32'h98, 1, 0);     chk_st("ovf_last", 0, 0, 0, 1, 3'd4);
        cyc(1, 0, 32'h0, 0, 0);      chk_st("err_clr", 1, 0, 0, 0, 3'd0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Bad checksum: three writes only, then ERROR.
        for (int i = 1; i <= 3; i++) cyc(0, 1, 32'(i), 0, 1);
        cyc(0, 1, 32'd7, 1, 1);      chk_st("ck_bad", 0, 0, 0, 1, 3'd3);
        chk("ck_bad.checksum", 64'(checksum), 64'(6));
        cyc(0, 0, 32'h0, 0, 0);      chk_st("ck_bad_hold", 0, 0, 0, 1, 3'd3);
`else
        // Exact fit: last word at the top address is legal.
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h50 + 32'(i), 0, 1);
        cyc(0, 1, 32'h53, 1, 1);     chk_st("fit", 0, 0, 0, 0, 3'd4);
        cyc(0, 0, 32'h0, 0, 0);      chk_st("fit_run", 0, 1, 1, 0, 3'd4);
`endif

        // Asynchronous reset in the middle of a load.
        cyc(1, 0, 32'h0, 0, 0);
        cyc(0, 1, 32'h61, 0, 1);
        cyc(0, 1, 32'h62, 0, 1);
        cyc(0, 0, 32'h0, 0, 0);
        #2 reset_n = 1'b0;
        #1 chk_st("async_rst", 0, 0, 0, 0, 3'd0);
        chk("async_rst.imem_addr", 64'(imem_addr), 64'(0));
        @(negedge clk) reset_n = 1'b1;
        cyc(0, 1, 32'h77, 0, 0);     chk_st("post_rst", 0, 0, 0, 0, 3'd0);

        chk("sb_drain", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
